// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing for the board reset sequencer.
// Imported by the sequencer, the wrapper and the bench.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_STRETCH = 2'd1,
        RS_RELEASE = 2'd2,
        RS_RUN     = 2'd3
    } rs_state_e;

    localparam int RS_DEF_NUM_CH  = 4;
    localparam int RS_DEF_CNT_W   = 12;
    localparam int RS_DEF_STRETCH = 4095;
    localparam int RS_DEF_STEP    = 16;
    localparam int RS_DEF_SYNC    = 2;

    function automatic int rs_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES clean edges.
// Reusable for any further reset domain hanging off the same board reset.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_n_i,
    output logic rst_n_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronise board reset, stretch it, then release
// NUM_CH reset domains in order, STEP cycles apart.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = RS_DEF_NUM_CH,
    parameter int CNT_W       = RS_DEF_CNT_W,
    parameter int STRETCH     = RS_DEF_STRETCH,
    parameter int STEP        = RS_DEF_STEP,
    parameter int SYNC_STAGES = RS_DEF_SYNC
) (
    input  logic              clk,
    input  logic              ext_rst_n,
    input  logic              soft_rst_req,
    input  logic [NUM_CH-1:0] ch_hold,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = rs_idx_w(NUM_CH);

    localparam logic [CNT_W-1:0] STR_LAST =
        (STRETCH > 0) ? CNT_W'(STRETCH - 1) : '0;
    localparam logic [CNT_W-1:0] STEP_LAST =
        (STEP > 0) ? CNT_W'(STEP - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    rs_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] rel_q, rel_d;
    logic              sync_rst_n;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk),
        .arst_n_i (ext_rst_n),
        .rst_n_o  (sync_rst_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        if (!sync_rst_n) begin
            state_d = RS_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
        end else if (soft_rst_req && state_q != RS_IDLE) begin
            // Restart wins over any release falling due this cycle.
            state_d = RS_STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
        end else begin
            unique case (state_q)
                RS_IDLE: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (STRETCH == 0) ? RS_RELEASE : RS_STRETCH;
                end
                RS_STRETCH: begin
                    if (STRETCH == 0 || cnt_q == STR_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = RS_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RS_RELEASE: begin
                    if (STEP == 0) begin
                        rel_d   = '1;
                        cnt_d   = '0;
                        state_d = RS_RUN;
                    end else if (cnt_q == '0) begin
                        rel_d[idx_q] = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            cnt_d   = '0;
                            state_d = RS_RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            cnt_d = (STEP_LAST == '0) ? '0 : CNT_W'(1);
                        end
                    end else begin
                        cnt_d = (cnt_q == STEP_LAST) ? '0 : cnt_q + 1'b1;
                    end
                end
                RS_RUN: begin
                    state_d = RS_RUN;
                end
                default: begin
                    state_d = RS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q   <= RS_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rel_q     <= '0;
            rst_out_n <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rel_q     <= rel_d;
            rst_out_n <= rel_d & ~ch_hold;
            busy      <= (state_d == RS_STRETCH) || (state_d == RS_RELEASE);
            done      <= (state_d == RS_RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations in lockstep against an
// elapsed-time reference model.
module tb_reset_sequencer;
    import rst_seq_pkg::*;

    localparam int SYNC = 2;

    logic       clk;
    logic       ext_rst_n;
    logic       soft_rst_req;
    logic [3:0] ch_hold;

    logic [3:0] rst_def;
    logic       busy_def, done_def;
    logic [2:0] rst_sm;
    logic       busy_sm, done_sm;
    logic [3:0] rst_mid;
    logic       busy_mid, done_mid;

    int nvec = 0;
    int nerr = 0;

    int   m_post  = 0;
    int   m_since = 0;
    bit   m_started = 1'b0;
    logic [3:0] m_hold = 4'h0;

    reset_sequencer u_def (
        .clk          (clk),
        .ext_rst_n    (ext_rst_n),
        .soft_rst_req (soft_rst_req),
        .ch_hold      (ch_hold),
        .rst_out_n    (rst_def),
        .busy         (busy_def),
        .done         (done_def)
    );

    reset_sequencer #(
        .NUM_CH  (3),
        .STRETCH (10),
        .STEP    (0)
    ) u_small (
        .clk          (clk),
        .ext_rst_n    (ext_rst_n),
        .soft_rst_req (soft_rst_req),
        .ch_hold      (ch_hold[2:0]),
        .rst_out_n    (rst_sm),
        .busy         (busy_sm),
        .done         (done_sm)
    );

    reset_sequencer #(
        .NUM_CH  (4),
        .STRETCH (20),
        .STEP    (3)
    ) u_mid (
        .clk          (clk),
        .ext_rst_n    (ext_rst_n),
        .soft_rst_req (soft_rst_req),
        .ch_hold      (ch_hold),
        .rst_out_n    (rst_mid),
        .busy         (busy_mid),
        .done         (done_mid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Channel i is free once stretch+1+i*step edges have passed since restart.
    function automatic logic [5:0] exp_dut(input int n, input int s,
                                           input int p);
        logic [3:0] r;
        logic       b;
        logic       d;
        int         last;
        r = 4'h0;
        b = 1'b0;
        d = 1'b0;
        if (m_started) begin
            for (int i = 0; i < n; i++)
                r[i] = (m_since >= s + 1 + i * p) && !m_hold[i];
            last = s + 1 + (n - 1) * p;
            d = (m_since >= last);
            b = !d;
        end
        return {r, b, d};
    endfunction

    function automatic logic [17:0] exp_all();
        return {exp_dut(4, RS_DEF_STRETCH, RS_DEF_STEP),
                exp_dut(3, 10, 0), exp_dut(4, 20, 3)};
    endfunction

    function automatic logic [17:0] obs_all();
        return {rst_def, busy_def, done_def,
                1'b0, rst_sm, busy_sm, done_sm,
                rst_mid, busy_mid, done_mid};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_hold = ch_hold;
        if (!ext_rst_n) begin
            m_started = 1'b0;
            m_post    = 0;
            m_since   = 0;
        end else begin
            m_post++;
            if (!m_started) begin
                if (m_post == SYNC + 1) begin
                    m_started = 1'b1;
                    m_since   = 0;
                end
            end else if (soft_rst_req) begin
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        ext_rst_n    = 1'b1;
        soft_rst_req = 1'b0;
        ch_hold      = 4'h0;
        #1 ext_rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL reset k=%0d got=%h want=%h",
                         k, obs_all(), exp_all());
            end
        end
        nvec++;
        if (obs_all() !== 18'h0) begin
            nerr++;
            $display("FAIL reset_zero got=%h want=0", obs_all());
        end
    endtask

    task automatic test_sequence();
        logic [5:0] want_def;
        logic [4:0] want_sm;
        ext_rst_n = 1'b1;
        for (int k = 1; k <= 4160; k++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL seq k=%0d got=%h want=%h",
                         k, obs_all(), exp_all());
            end
            want_def = 6'h3f;
            case (k)
                4098: want_def = {4'b0000, 2'b10};
                4099: want_def = {4'b0001, 2'b10};
                4115: want_def = {4'b0011, 2'b10};
                4131: want_def = {4'b0111, 2'b10};
                4146: want_def = {4'b0111, 2'b10};
                4147: want_def = {4'b1111, 2'b01};
                default: ;
            endcase
            if (want_def != 6'h3f) begin
                nvec++;
                if ({rst_def, busy_def, done_def} !== want_def) begin
                    nerr++;
                    $display("FAIL seq_def k=%0d got=%b want=%b", k,
                             {rst_def, busy_def, done_def}, want_def);
                end
            end
            if (k == 13 || k == 14) begin
                want_sm = (k == 13) ? 5'b000_10 : 5'b111_01;
                nvec++;
                if ({rst_sm, busy_sm, done_sm} !== want_sm) begin
                    nerr++;
                    $display("FAIL seq_small k=%0d got=%b want=%b", k,
                             {rst_sm, busy_sm, done_sm}, want_sm);
                end
            end
        end
    endtask

    task automatic test_soft_pulse();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        nvec++;
        if ({rst_def, busy_def, done_def} !== 6'b0000_10) begin
            nerr++;
            $display("FAIL soft_assert got=%b want=000010",
                     {rst_def, busy_def, done_def});
        end
        for (int j = 1; j <= 4150; j++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL soft j=%0d got=%h want=%h",
                         j, obs_all(), exp_all());
            end
            if (j == 4095 || j == 4096 || j == 4112 || j == 4144) begin
                nvec++;
                if (rst_def !== ((j == 4095) ? 4'b0000 :
                                 (j == 4096) ? 4'b0001 :
                                 (j == 4112) ? 4'b0011 : 4'b1111)) begin
                    nerr++;
                    $display("FAIL soft_rel j=%0d got=%b", j, rst_def);
                end
            end
        end
    endtask

    task automatic test_hold();
        ch_hold      = 4'b0100;
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int j = 1; j <= 4150; j++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL hold j=%0d got=%h want=%h",
                         j, obs_all(), exp_all());
            end
            if (j == 4128 || j == 4144) begin
                nvec++;
                if ({rst_def, done_def} !==
                    ((j == 4128) ? 5'b0011_0 : 5'b1011_1)) begin
                    nerr++;
                    $display("FAIL hold_ch j=%0d got=%b", j,
                             {rst_def, done_def});
                end
            end
        end
        ch_hold = 4'b0000;
        tick();
        nvec++;
        if (rst_def !== 4'b1111) begin
            nerr++;
            $display("FAIL hold_drop got=%b want=1111", rst_def);
        end
    endtask

    task automatic test_async_mid();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int j = 1; j <= 4112; j++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL amid j=%0d got=%h want=%h",
                         j, obs_all(), exp_all());
            end
        end
        nvec++;
        if (rst_def !== 4'b0011) begin
            nerr++;
            $display("FAIL amid_pre got=%b want=0011", rst_def);
        end
        #1 ext_rst_n = 1'b0;
        m_started = 1'b0;
        m_post    = 0;
        m_since   = 0;
        #1;
        nvec++;
        if (obs_all() !== 18'h0) begin
            nerr++;
            $display("FAIL amid_async got=%h want=0", obs_all());
        end
        for (int k = 0; k < 3; k++) tick();
        ext_rst_n = 1'b1;
        for (int k = 1; k <= 4150; k++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL amid_re k=%0d got=%h want=%h",
                         k, obs_all(), exp_all());
            end
            if (k == 4098 || k == 4099 || k == 4147) begin
                nvec++;
                if (rst_def !== ((k == 4098) ? 4'b0000 :
                                 (k == 4099) ? 4'b0001 : 4'b1111)) begin
                    nerr++;
                    $display("FAIL amid_lat k=%0d got=%b", k, rst_def);
                end
            end
        end
    endtask

    task automatic test_soft_at_release();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int j = 1; j <= 4094; j++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL sar j=%0d got=%h want=%h",
                         j, obs_all(), exp_all());
            end
        end
        soft_rst_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            nvec++;
            if ({rst_def, busy_def, done_def} !== 6'b0000_10) begin
                nerr++;
                $display("FAIL sar_hold j=%0d got=%b want=000010", j,
                         {rst_def, busy_def, done_def});
            end
        end
        soft_rst_req = 1'b0;
        for (int j = 1; j <= 4100; j++) begin
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL sar_re j=%0d got=%h want=%h",
                         j, obs_all(), exp_all());
            end
            if (j == 4095 || j == 4096) begin
                nvec++;
                if (rst_def !== ((j == 4095) ? 4'b0000 : 4'b0001)) begin
                    nerr++;
                    $display("FAIL sar_rel j=%0d got=%b", j, rst_def);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            soft_rst_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 63) == 0)
                ch_hold = 4'($urandom_range(0, 15));
            if (ext_rst_n && $urandom_range(0, 799) == 0)
                ext_rst_n = 1'b0;
            else
                ext_rst_n = 1'b1;
            tick();
            nvec++;
            if (obs_all() !== exp_all()) begin
                nerr++;
                $display("FAIL rand j=%0d got=%h want=%h",
                         j, obs_all(), exp_all());
            end
        end
        soft_rst_req = 1'b0;
        ch_hold      = 4'h0;
        ext_rst_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_soft_pulse();
        test_hold();
        test_async_mid();
        test_soft_at_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
